// File: rtl/team_07_wb_arbiter.sv
// Two-master Wishbone classic-cycle arbiter: round-robin grant, one transfer per grant,
// and a bounded wait so a hung slave cannot lock out either master.
//
// state | meaning
// IDLE  | no owner, slave port quiet, arbitrate pending requests
// BUSY  | owner drives the slave port, waiting for ack / abort / timeout
// TERM  | one-cycle forced termination, owner gets ack with ERR_DATA
module team_07_wb_arbiter #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic        m0_ack_o,
  output logic [31:0] m0_dat_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic [31:0] m1_dat_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,
  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_TERM = 2'd2
  } state_t;

  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  state_t      state;
  logic        owner;
  logic        last;
  logic [15:0] cnt;
  logic [1:0]  grant_q;
  logic        timeout_q;

  logic        req0, req1, pick;
  logic        own_cyc, own_stb, own_we;
  logic [3:0]  own_sel;
  logic [31:0] own_adr, own_dat;
  logic [15:0] cnt_inc;
  logic        busy, term, ack_fwd, ack_any;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;
  // On a tie the master that did not finish last wins; a lone requester always wins.
  assign pick = (req0 & req1) ? ~last : req1;

  assign own_cyc = owner ? m1_cyc_i : m0_cyc_i;
  assign own_stb = owner ? m1_stb_i : m0_stb_i;
  assign own_we  = owner ? m1_we_i  : m0_we_i;
  assign own_sel = owner ? m1_sel_i : m0_sel_i;
  assign own_adr = owner ? m1_adr_i : m0_adr_i;
  assign own_dat = owner ? m1_dat_i : m0_dat_i;

  assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= ST_IDLE;
      owner     <= 1'b0;
      last      <= 1'b1;
      cnt       <= 16'd0;
      grant_q   <= 2'b00;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt       <= 16'd0;
          timeout_q <= 1'b0;
          if (req0 | req1) begin
            owner   <= pick;
            grant_q <= pick ? 2'b10 : 2'b01;
            state   <= ST_BUSY;
          end else begin
            grant_q <= 2'b00;
          end
        end
        ST_BUSY: begin
          if (!own_cyc || s_ack_i) begin
            // abort (cyc dropped) or normal completion both hand priority away
            last    <= owner;
            cnt     <= 16'd0;
            grant_q <= 2'b00;
            state   <= ST_IDLE;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc >= TIMEOUT_C) begin
              timeout_q <= 1'b1;
              state     <= ST_TERM;
            end
          end
        end
        ST_TERM: begin
          last      <= owner;
          cnt       <= 16'd0;
          grant_q   <= 2'b00;
          timeout_q <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          cnt       <= 16'd0;
          grant_q   <= 2'b00;
          timeout_q <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy    = (state == ST_BUSY);
  assign term    = (state == ST_TERM);
  assign ack_fwd = busy & own_cyc & s_ack_i;
  assign ack_any = ack_fwd | term;

  assign s_cyc_o = busy & own_cyc;
  assign s_stb_o = busy & own_stb;
  assign s_we_o  = busy & own_we;
  assign s_sel_o = busy ? own_sel : 4'h0;
  assign s_adr_o = busy ? own_adr : 32'h0;
  assign s_dat_o = busy ? own_dat : 32'h0;

  assign m0_ack_o = ~owner & ack_any;
  assign m1_ack_o =  owner & ack_any;
  assign m0_dat_o = (~owner & busy) ? s_dat_i : (~owner & term) ? ERR_DATA : 32'h0;
  assign m1_dat_o = ( owner & busy) ? s_dat_i : ( owner & term) ? ERR_DATA : 32'h0;

  assign grant_o   = grant_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_team_07_wb_arbiter.sv
// Directed bench for the two-master Wishbone arbiter (TIMEOUT = 8); inputs change on
// the falling edge, outputs are checked 1 ns later.
module tb_team_07_wb_arbiter;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [3:0]  m0_sel_i;
  logic [31:0] m0_adr_i, m0_dat_i;
  logic        m0_ack_o;
  logic [31:0] m0_dat_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [3:0]  m1_sel_i;
  logic [31:0] m1_adr_i, m1_dat_i;
  logic        m1_ack_o;
  logic [31:0] m1_dat_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic        s_ack_i;
  logic [31:0] s_dat_i;
  logic [1:0]  grant_o;
  logic        timeout_o;

  int checks = 0;
  int errors = 0;

  team_07_wb_arbiter #(.TIMEOUT(8), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_ack_o(m0_ack_o), .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_ack_o(m1_ack_o), .m1_dat_o(m1_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nedge();
    @(negedge wb_clk_i);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench did not complete");
  end

  initial begin
    wb_rst_i = 1'b1;
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_sel_i = 4'h0; m0_adr_i = 0; m0_dat_i = 0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_sel_i = 4'h0; m1_adr_i = 0; m1_dat_i = 0;
    s_ack_i = 0; s_dat_i = 0;

    // reset state
    nedge(); nedge(); #1;
    chk("rst_grant", 32'(grant_o), 32'h0);
    chk("rst_s_cyc", 32'(s_cyc_o), 32'h0);
    chk("rst_timeout", 32'(timeout_o), 32'h0);
    chk("rst_m0_ack", 32'(m0_ack_o), 32'h0);

    // both masters request together, four round-robin reads: owners 0,1,0,1
    nedge();
    wb_rst_i = 1'b0;
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_sel_i = 4'hF; m0_adr_i = 32'h10;
    m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 0; m1_sel_i = 4'hF; m1_adr_i = 32'h20;
    #1;
    chk("rr_idle_grant", 32'(grant_o), 32'h0);
    for (int i = 0; i < 4; i++) begin
      nedge();
      s_ack_i = 1;
      s_dat_i = (i % 2 == 0) ? 32'hAAAA_0010 : 32'hAAAA_0020;
      #1;
      if (i % 2 == 0) begin
        chk("rr_grant_m0", 32'(grant_o), 32'h1);
        chk("rr_s_adr_m0", s_adr_o, 32'h10);
        chk("rr_m0_ack", 32'(m0_ack_o), 32'h1);
        chk("rr_m0_dat", m0_dat_o, 32'hAAAA_0010);
        chk("rr_m1_ack_idle", 32'(m1_ack_o), 32'h0);
        chk("rr_m1_dat_idle", m1_dat_o, 32'h0);
      end else begin
        chk("rr_grant_m1", 32'(grant_o), 32'h2);
        chk("rr_s_adr_m1", s_adr_o, 32'h20);
        chk("rr_m1_ack", 32'(m1_ack_o), 32'h1);
        chk("rr_m1_dat", m1_dat_o, 32'hAAAA_0020);
        chk("rr_m0_ack_idle", 32'(m0_ack_o), 32'h0);
        chk("rr_m0_dat_idle", m0_dat_o, 32'h0);
      end
      nedge();
      s_ack_i = 0; s_dat_i = 0;
      if (i == 3) begin
        m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
      end
      #1;
      chk("rr_gap_grant", 32'(grant_o), 32'h0);
      chk("rr_gap_m0_ack", 32'(m0_ack_o), 32'h0);
      chk("rr_gap_m1_ack", 32'(m1_ack_o), 32'h0);
    end

    // single master 0 write, ack in second BUSY cycle
    nedge();
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_sel_i = 4'hF;
    m0_adr_i = 32'h3000_0004; m0_dat_i = 32'h1234_5678;
    #1;
    chk("wr_pre_grant", 32'(grant_o), 32'h0);
    chk("wr_pre_s_cyc", 32'(s_cyc_o), 32'h0);
    nedge(); #1;
    chk("wr_grant", 32'(grant_o), 32'h1);
    chk("wr_s_cyc", 32'(s_cyc_o), 32'h1);
    chk("wr_s_we", 32'(s_we_o), 32'h1);
    chk("wr_s_sel", 32'(s_sel_o), 32'hF);
    chk("wr_s_adr", s_adr_o, 32'h3000_0004);
    chk("wr_s_dat", s_dat_o, 32'h1234_5678);
    chk("wr_m0_ack_early", 32'(m0_ack_o), 32'h0);
    nedge();
    s_ack_i = 1;
    #1;
    chk("wr_m0_ack", 32'(m0_ack_o), 32'h1);
    chk("wr_m1_ack", 32'(m1_ack_o), 32'h0);
    nedge();
    s_ack_i = 0;
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0;
    #1;
    chk("wr_done_grant", 32'(grant_o), 32'h0);
    chk("wr_done_m0_ack", 32'(m0_ack_o), 32'h0);
    chk("wr_done_s_cyc", 32'(s_cyc_o), 32'h0);

    // master 0 aborts in third BUSY cycle, master 1 pending
    nedge();
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h50;
    m1_adr_i = 32'h60;
    #1;
    nedge();
    m1_cyc_i = 1; m1_stb_i = 1;
    #1;
    chk("ab_grant_b1", 32'(grant_o), 32'h1);
    chk("ab_s_adr", s_adr_o, 32'h50);
    chk("ab_m1_stall", 32'(m1_ack_o), 32'h0);
    nedge(); #1;
    chk("ab_grant_b2", 32'(grant_o), 32'h1);
    nedge();
    m0_cyc_i = 0; m0_stb_i = 0;
    #1;
    chk("ab_drop_s_cyc", 32'(s_cyc_o), 32'h0);
    chk("ab_drop_m0_ack", 32'(m0_ack_o), 32'h0);
    nedge(); #1;
    chk("ab_idle_grant", 32'(grant_o), 32'h0);
    chk("ab_idle_s_cyc", 32'(s_cyc_o), 32'h0);
    chk("ab_idle_m0_ack", 32'(m0_ack_o), 32'h0);
    chk("ab_idle_m1_ack", 32'(m1_ack_o), 32'h0);
    nedge(); #1;
    chk("ab_m1_grant", 32'(grant_o), 32'h2);
    chk("ab_m1_s_adr", s_adr_o, 32'h60);
    nedge();
    s_ack_i = 1; s_dat_i = 32'hAAAA_0060;
    #1;
    chk("ab_m1_ack", 32'(m1_ack_o), 32'h1);
    chk("ab_m1_dat", m1_dat_o, 32'hAAAA_0060);
    chk("ab_m0_ack", 32'(m0_ack_o), 32'h0);
    nedge();
    s_ack_i = 0; s_dat_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    #1;
    chk("ab_end_grant", 32'(grant_o), 32'h0);

    // master 1 read, slave never acks: TERM is the 9th cycle after BUSY entry
    nedge();
    m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 0; m1_adr_i = 32'h44;
    #1;
    nedge();
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_adr_i = 32'h70;
    #1;
    chk("to_grant_b1", 32'(grant_o), 32'h2);
    chk("to_s_cyc_b1", 32'(s_cyc_o), 32'h1);
    chk("to_timeout_b1", 32'(timeout_o), 32'h0);
    for (int k = 2; k <= 8; k++) begin
      nedge(); #1;
      chk("to_busy_timeout", 32'(timeout_o), 32'h0);
      chk("to_busy_m1_ack", 32'(m1_ack_o), 32'h0);
      chk("to_busy_s_cyc", 32'(s_cyc_o), 32'h1);
    end
    nedge(); #1;
    chk("to_term_timeout", 32'(timeout_o), 32'h1);
    chk("to_term_m1_ack", 32'(m1_ack_o), 32'h1);
    chk("to_term_m1_dat", m1_dat_o, 32'hDEAD_BEEF);
    chk("to_term_s_cyc", 32'(s_cyc_o), 32'h0);
    chk("to_term_s_stb", 32'(s_stb_o), 32'h0);
    chk("to_term_grant", 32'(grant_o), 32'h2);
    chk("to_term_m0_ack", 32'(m0_ack_o), 32'h0);
    m1_cyc_i = 0; m1_stb_i = 0;
    nedge(); #1;
    chk("to_post_timeout", 32'(timeout_o), 32'h0);
    chk("to_post_grant", 32'(grant_o), 32'h0);
    chk("to_post_m1_ack", 32'(m1_ack_o), 32'h0);
    nedge(); #1;
    chk("to_next_grant_m0", 32'(grant_o), 32'h1);
    chk("to_next_s_adr", s_adr_o, 32'h70);
    nedge();
    s_ack_i = 1;
    #1;
    chk("to_next_m0_ack", 32'(m0_ack_o), 32'h1);
    nedge();
    s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    #1;
    chk("to_end_grant", 32'(grant_o), 32'h0);

    // reset mid-BUSY with ack high; afterwards a tie goes to master 0
    nedge();
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h80;
    #1;
    nedge(); #1;
    chk("rb_grant", 32'(grant_o), 32'h1);
    s_ack_i = 1; s_dat_i = 32'h55;
    #1;
    wb_rst_i = 1;
    #1;
    chk("rb_grant_async", 32'(grant_o), 32'h0);
    chk("rb_m0_ack_async", 32'(m0_ack_o), 32'h0);
    chk("rb_m0_dat_async", m0_dat_o, 32'h0);
    chk("rb_s_cyc_async", 32'(s_cyc_o), 32'h0);
    chk("rb_s_adr_async", s_adr_o, 32'h0);
    chk("rb_timeout_async", 32'(timeout_o), 32'h0);
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h90;
    nedge();
    s_ack_i = 0; s_dat_i = 0; wb_rst_i = 0;
    #1;
    chk("rb_release_grant", 32'(grant_o), 32'h0);
    nedge(); #1;
    chk("rb_tie_grant_m0", 32'(grant_o), 32'h1);
    chk("rb_tie_s_adr", s_adr_o, 32'h80);
    nedge();
    s_ack_i = 1;
    #1;
    chk("rb_m0_ack", 32'(m0_ack_o), 32'h1);
    chk("rb_m1_ack", 32'(m1_ack_o), 32'h0);
    nedge();
    s_ack_i = 0;
    m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    #1;
    chk("rb_end_grant", 32'(grant_o), 32'h0);

    // stray slave ack while idle is not forwarded and does not leave IDLE
    nedge();
    s_ack_i = 1;
    #1;
    chk("st_m0_ack", 32'(m0_ack_o), 32'h0);
    chk("st_m1_ack", 32'(m1_ack_o), 32'h0);
    nedge(); #1;
    chk("st_grant", 32'(grant_o), 32'h0);
    chk("st_s_cyc", 32'(s_cyc_o), 32'h0);
    chk("st_m0_ack2", 32'(m0_ack_o), 32'h0);
    s_ack_i = 0;
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'hA0;
    nedge(); #1;
    chk("st_grant_after", 32'(grant_o), 32'h2);
    chk("st_s_adr_after", s_adr_o, 32'hA0);
    nedge();
    s_ack_i = 1;
    #1;
    chk("st_m1_ack_after", 32'(m1_ack_o), 32'h1);
    nedge();
    s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    #1;
    chk("st_end_grant", 32'(grant_o), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
